// File: rtl/booth_result_bcd.sv
// booth_result_bcd: signed 2N-bit product to sign + packed BCD via
// one-bit-per-clock double-dabble. Ports: clk, rst (async active-low),
// valid/binario in; busy, done, signo, bcd, blank out.
// Optional leading-zero blanking mask enabled by macro BCD_BLANK_EN.
module booth_result_bcd #(
   parameter int N      = 8,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [2*N-1:0]        binario,
   output logic                  busy,
   output logic                  done,
   output logic                  signo,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank
);

   localparam int W  = 2 * N;
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    mag;
   logic [BW-1:0]   acc, acc_nxt;
   logic [CW-1:0]   cnt;
   logic            sign_r;
   logic            start, last;

   // add 3 to every digit >= 5 ahead of the shift
   function automatic logic [BW-1:0] adj3(input logic [BW-1:0] a);
      logic [BW-1:0] r;
      r = a;
      for (int i = 0; i < DIGITS; i++)
         if (a[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      return r;
   endfunction

   // the digit-range rule guarantees the dropped top bit is zero
   assign acc_nxt = BW'({adj3(acc), mag[W-1]});
   assign busy    = (state == CONVERT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      last      = 1'b0;
      unique case (state)
         IDLE: begin
            if (valid) begin
               start     = 1'b1;
               state_nxt = CONVERT;
            end
         end
         CONVERT: begin
            if (cnt == LAST) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mag    <= '0;
         acc    <= '0;
         cnt    <= '0;
         sign_r <= 1'b0;
         done   <= 1'b0;
         signo  <= 1'b0;
         bcd    <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            sign_r <= binario[W-1];
            // most negative value maps to 2^(W-1) without overflow
            mag    <= binario[W-1] ? (~binario + 1'b1) : binario;
            acc    <= '0;
            cnt    <= '0;
         end else if (state == CONVERT) begin
            acc <= acc_nxt;
            mag <= {mag[W-2:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (last) begin
               bcd   <= acc_nxt;
               signo <= sign_r;
               done  <= 1'b1;
            end
         end
      end
   end

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_nxt, blank_r;

   // a digit blanks when it and every digit above it are zero
   always_comb begin
      logic seen;
      seen      = 1'b0;
      blank_nxt = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (acc_nxt[4*i +: 4] != 4'd0) seen = 1'b1;
         blank_nxt[i] = ~seen;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      blank_r <= '0;
      else if (last) blank_r <= blank_nxt;
   end

   assign blank = blank_r;
`else
   assign blank = '0;
`endif

endmodule

// File: tb/tb_booth_result_bcd.sv
// tb_booth_result_bcd: random and directed conversions, scoreboard
// with decimal reference model and latency tracking.
module tb_booth_result_bcd;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic [15:0] binario = '0;
   logic        busy, done, signo;
   logic [19:0] bcd;
   logic [4:0]  blank;

   typedef struct {
      logic        s;
      logic [19:0] b;
      logic [4:0]  bl;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   booth_result_bcd #(.N(8), .DIGITS(5)) dut (
      .clk(clk), .rst(rst), .valid(valid), .binario(binario),
      .busy(busy), .done(done), .signo(signo), .bcd(bcd),
      .blank(blank)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // decimal reference: magnitude digits by division
   function automatic exp_t model(input int v, input int c);
      exp_t e;
      int   m, top;
      e.s  = (v < 0);
      m    = (v < 0) ? -v : v;
      e.b  = '0;
      top  = 0;
      for (int d = 0; d < 5; d++) begin
         e.b[4*d +: 4] = 4'(m % 10);
         if (m % 10 != 0) top = d;
         m = m / 10;
      end
      e.bl = '0;
`ifdef BCD_BLANK_EN
      for (int d = 1; d < 5; d++)
         if (d > top) e.bl[d] = 1'b1;
`endif
      e.cyc = c;
      return e;
   endfunction

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (busy) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic start(input int v);
      wait_idle();
      valid   = 1'b1;
      binario = 16'(v);
      q.push_back(model(v, cyc + 17));
      @(negedge clk);
      valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst && done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("signo", 32'(signo), 32'(e.s));
            chk("bcd", 32'(bcd), 32'(e.b));
            chk("blank", 32'(blank), 32'(e.bl));
            chk("latency", cyc, e.cyc);
            chk("busy_after", 32'(busy), 32'd0);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_signo", 32'(signo), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_blank", 32'(blank), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      start(9801);
      start(-9801);
      start(0);
      start(-32768);
      start(32767);
      start(100);
      start(0);

      // valid mid-conversion ignored; binario changes ignored
      start(2500);
      repeat (3) @(negedge clk);
      valid   = 1'b1;
      binario = 16'(-100);
      @(negedge clk);
      valid = 1'b0;
      repeat (2) @(negedge clk);
      binario = 16'h1234;

      // valid held high: back-to-back conversions, 2N+1 apart
      wait_idle();
      valid   = 1'b1;
      binario = 16'(-4321);
      q.push_back(model(-4321, cyc + 17));
      q.push_back(model(-4321, cyc + 34));
      repeat (18) @(negedge clk);
      valid = 1'b0;

      // reset mid-conversion aborts with no done
      start(1234);
      repeat (6) @(negedge clk);
      rst = 1'b0;
      #1;
      void'(q.pop_back());
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_signo", 32'(signo), 32'd0);
      chk("abort_bcd", 32'(bcd), 32'd0);
      chk("abort_blank", 32'(blank), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      start(-225);

      for (int i = 0; i < 40; i++)
         start(int'($urandom_range(0, 65535)) - 32768);

      for (int k = 0; k < 200 && q.size() != 0; k++)
         @(negedge clk);
      chk("queue_drained", q.size(), 0);
      repeat (20) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/booth_result_bcd.md
Name: booth_result_bcd

Overview:
- Sequential signed-binary-to-BCD converter placed directly downstream of the Booth multiplier.
- Captures the 2N-bit two's-complement product when the multiplier pulses its completion flag, then produces a sign bit plus packed BCD digits for the 7-segment display driver.
- Uses an iterative shift-add-3 (double-dabble) datapath with one bit per clock, to keep area small on the 27 MHz FPGA.

Parameters:
- N, 8: operand width of the upstream multiplier; the input product is 2N bits.
- DIGITS, 5: number of BCD output digits. Must satisfy 10^DIGITS > 2^(2N-1); a value of 5 covers 32768.

Ports:
- clk  input  1  system clock, 27 MHz.
- rst  input  1  asynchronous, active-low reset.
- valid  input  1  start strobe; driven by the multiplier's done.
- binario  input  2N  signed two's-complement product; driven by the multiplier's resultado.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when outputs are updated.
- signo  output  1  1 = negative result.
- bcd  output  4*DIGITS  packed magnitude digits; digit 0 (units) is in [3:0].
- blank  output  DIGITS  leading-zero mask; see Optional Feature.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - While rst=0: state=IDLE, busy=0, done=0, signo=0, bcd=0, blank=0, internal shift and count registers cleared.
  - Reset asserted mid-conversion aborts the conversion immediately; no done is produced.
- States: IDLE, CONVERT.
- IDLE:
  - On a rising edge with valid=1 (edge E0), capture signo=binario[2N-1] into an internal register.
  - Capture the magnitude as an unsigned 2N-bit value: binario if non-negative, (~binario+1) otherwise. -2^(2N-1) yields magnitude 2^(2N-1) with no overflow.
  - Clear the BCD accumulator, set count=0, set busy=1, go to CONVERT.
- CONVERT, on each edge E1..E2N:
  - Add 3 to every accumulator digit that is >= 5.
  - Shift {accumulator, magnitude} left by one bit.
  - count++.
- Final edge E2N:
  - Load the adjusted and shifted accumulator into bcd, load signo into the signo output, load blank.
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: done goes high 2N clock edges after the capture edge (16 for N=8). Throughput: one conversion per 2N+1 cycles.
- Output holding: bcd, signo and blank hold the last result between conversions and change only on the done edge.
- Input handling:
  - valid while busy=1 is ignored. No queuing, no restart.
  - valid held high continuously starts a new conversion at the first edge after returning to IDLE.
  - binario is sampled only at E0. Changes during CONVERT have no effect.
- Zero result: signo=0. An input of 0 never reports negative.
- Every digit in bcd is always in the range 0..9.

Optional Feature:
- Macro: BCD_BLANK_EN.
- Defined: at the done edge, blank[i]=1 for each digit i>=1 that is zero and has only zero digits above it. blank[0] is always 0, so the units digit is always shown.
- Not defined: blank is tied to all zeros and no blanking logic is synthesised.

Test Plan:
- Reset, then valid with binario=9801 (99*99) -> done exactly 16 cycles later; signo=0, bcd=0x09801, busy low after done.
- binario=-9801 -> signo=1, bcd=0x09801. Then binario=0 -> signo=0, bcd=0x00000.
- binario=-32768 and binario=32767 -> {1, 0x32768} and {0, 0x32767}.
- Start a conversion with 2500, pulse valid with -100 at cycle 5 and change binario at cycle 8 -> single done with {0, 0x02500}, no second done.
- Assert rst low at cycle 7 of a conversion -> all outputs 0 immediately, no done. After release, a new conversion of -225 -> {1, 0x00225}.
- With BCD_BLANK_EN: input 100 -> blank=5'b11000; input 0 -> blank=5'b11110. Without the macro, blank stays 0 for both inputs.
